// File: rtl/alu_control_pipe.sv
// ALU control decoder for the LEGv8 datapath: maps ALUop/Opcode to ALUCtrl
// through a DEPTH-stage valid/ready pipeline, with illegal-input tracking.
module alu_control_pipe #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       ALUop,
    input  logic [10:0]      Opcode,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [3:0]       ALUCtrl,
    output logic             Illegal,
    output logic             IllegalSticky,
    output logic [CNT_W-1:0] ErrCount,
    input  logic             ClearErr
);

    localparam logic [3:0] CTRL_AND     = 4'b0000;
    localparam logic [3:0] CTRL_ORR     = 4'b0001;
    localparam logic [3:0] CTRL_ADD     = 4'b0010;
    localparam logic [3:0] CTRL_EOR     = 4'b0011;
    localparam logic [3:0] CTRL_LSL     = 4'b0100;
    localparam logic [3:0] CTRL_LSR     = 4'b0101;
    localparam logic [3:0] CTRL_SUB     = 4'b0110;
    localparam logic [3:0] CTRL_PASS_B  = 4'b0111;
    localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef struct packed {
        logic       valid;
        logic [3:0] ctrl;
        logic       illegal;
    } stage_t;

    logic [3:0]       dec_ctrl;
    logic             dec_illegal;
    stage_t           stage_q   [DEPTH];
    stage_t           stage_src [DEPTH];
    logic [DEPTH-1:0] stage_ready;
    logic             accept_illegal;

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_ctrl = CTRL_ILLEGAL;
        case (ALUop)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_PASS_B;
            2'b10: begin
                case (Opcode)
                    11'b10001011000: dec_ctrl = CTRL_ADD;
                    11'b11001011000: dec_ctrl = CTRL_SUB;
                    11'b10001010000: dec_ctrl = CTRL_AND;
                    11'b10101010000: dec_ctrl = CTRL_ORR;
                    11'b11001010000: dec_ctrl = CTRL_EOR;
                    11'b11010011011: dec_ctrl = CTRL_LSL;
                    11'b11010011010: dec_ctrl = CTRL_LSR;
                    default:         dec_ctrl = CTRL_ILLEGAL;
                endcase
            end
            2'b11: begin
                // Immediate class ignores Opcode[0].
                case (Opcode[10:1])
                    10'b1001000100: dec_ctrl = CTRL_ADD;
                    10'b1101000100: dec_ctrl = CTRL_SUB;
                    default:        dec_ctrl = CTRL_ILLEGAL;
                endcase
            end
            default: dec_ctrl = CTRL_ILLEGAL;
        endcase
        // 1111 is never a legal code, so it doubles as the illegal marker.
        dec_illegal = (dec_ctrl == CTRL_ILLEGAL);
    end

    // Stage k may load iff some stage at or after k is empty, or the output drains.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        stage_ready = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            all_full       = all_full & stage_q[k].valid;
            stage_ready[k] = OutReady || !all_full;
        end
    end

    always_comb begin
        stage_src[0] = '{valid: InValid, ctrl: dec_ctrl, illegal: dec_illegal};
        for (int k = 1; k < DEPTH; k++) begin
            stage_src[k] = stage_q[k-1];
        end
    end

    // NOTE: payload fields are reset as well as valids, because ALUCtrl/Illegal must read 0 right after reset.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                // NOTE: non-blocking assignment keeps every stage reading its predecessor's pre-edge value.
                if (stage_ready[k]) begin
                    stage_q[k] <= stage_src[k];
                end
            end
        end
    end

    assign accept_illegal = InValid && InReady && dec_illegal;

    // Clear takes effect before a same-cycle increment.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            IllegalSticky <= 1'b0;
            ErrCount      <= '0;
        end else if (ClearErr) begin
            IllegalSticky <= accept_illegal;
            ErrCount      <= accept_illegal ? CNT_W'(1) : '0;
        end else if (accept_illegal) begin
            IllegalSticky <= 1'b1;
            if (ErrCount != CNT_MAX) begin
                ErrCount <= ErrCount + CNT_W'(1);
            end
        end
    end

    assign InReady  = stage_ready[0];
    assign OutValid = stage_q[DEPTH-1].valid;
    assign ALUCtrl  = stage_q[DEPTH-1].ctrl;
    assign Illegal  = stage_q[DEPTH-1].illegal;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Self-checking bench for alu_control_pipe (DEPTH=2, CNT_W=2): directed steps
// with a scoreboard of expected {ALUCtrl, Illegal} results and error-count model.
module tb_alu_control_pipe;

    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             CLK;
    logic             RESETn;
    logic             InValid;
    logic             InReady;
    logic [1:0]       ALUop;
    logic [10:0]      Opcode;
    logic             OutValid;
    logic             OutReady;
    logic [3:0]       ALUCtrl;
    logic             Illegal;
    logic             IllegalSticky;
    logic [CNT_W-1:0] ErrCount;
    logic             ClearErr;

    alu_control_pipe #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .InValid       (InValid),
        .InReady       (InReady),
        .ALUop         (ALUop),
        .Opcode        (Opcode),
        .OutValid      (OutValid),
        .OutReady      (OutReady),
        .ALUCtrl       (ALUCtrl),
        .Illegal       (Illegal),
        .IllegalSticky (IllegalSticky),
        .ErrCount      (ErrCount),
        .ClearErr      (ClearErr)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int exp_cnt = 0;
    logic exp_sticky = 1'b0;
    logic mon_en = 1'b0;
    logic [4:0] sb [$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written straight from the opcode table.
    function automatic logic [4:0] model(input logic [1:0] op, input logic [10:0] opc);
        logic [9:0] hi;
        hi = opc[10:1];
        if (op === 2'b00) return {4'b0010, 1'b0};
        if (op === 2'b01) return {4'b0111, 1'b0};
        if (op === 2'b10) begin
            if (opc === 11'b10001011000) return {4'b0010, 1'b0};
            if (opc === 11'b11001011000) return {4'b0110, 1'b0};
            if (opc === 11'b10001010000) return {4'b0000, 1'b0};
            if (opc === 11'b10101010000) return {4'b0001, 1'b0};
            if (opc === 11'b11001010000) return {4'b0011, 1'b0};
            if (opc === 11'b11010011011) return {4'b0100, 1'b0};
            if (opc === 11'b11010011010) return {4'b0101, 1'b0};
        end
        if (op === 2'b11) begin
            if (hi === 10'b1001000100) return {4'b0010, 1'b0};
            if (hi === 10'b1101000100) return {4'b0110, 1'b0};
        end
        return {4'b1111, 1'b1};
    endfunction

    // Handshakes are evaluated at the falling edge; inputs stay put until the next rising edge.
    always @(negedge CLK) begin
        logic [4:0] e;
        logic acc_ill;
        if (mon_en) begin
            check("err_count", 16'(ErrCount), 16'(exp_cnt));
            check("sticky", 16'(IllegalSticky), 16'(exp_sticky));
        end
        if (!RESETn) begin
            sb.delete();
            exp_cnt    = 0;
            exp_sticky = 1'b0;
        end else begin
            if (OutValid && OutReady) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL unexpected_output observed=%0h expected=none", {ALUCtrl, Illegal});
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("result", 16'({ALUCtrl, Illegal}), 16'(e));
                    pops++;
                end
            end
            acc_ill = 1'b0;
            if (InValid && InReady) begin
                e = model(ALUop, Opcode);
                sb.push_back(e);
                acc_ill = e[0];
            end
            if (ClearErr) begin
                exp_cnt    = acc_ill ? 1 : 0;
                exp_sticky = acc_ill;
            end else if (acc_ill) begin
                exp_sticky = 1'b1;
                if (exp_cnt < 3) exp_cnt++;
            end
        end
    end

    task automatic offer(input logic [1:0] op, input logic [10:0] opc, output int waits);
        logic got;
        InValid = 1'b1;
        ALUop   = op;
        Opcode  = opc;
        waits   = 0;
        got     = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (InReady === 1'b1) got = 1'b1;
            else waits++;
        end
        check("offer_ready", 16'(got), 16'd1);
        @(posedge CLK);
        #1;
    endtask

    logic [12:0] tbl [12] = '{
        {2'b00, 11'b00000000000}, {2'b01, 11'b10110100000},
        {2'b10, 11'b10001011000}, {2'b10, 11'b11001011000},
        {2'b10, 11'b10001010000}, {2'b10, 11'b10101010000},
        {2'b10, 11'b11001010000}, {2'b10, 11'b11010011011},
        {2'b10, 11'b11010011010}, {2'b11, 11'b10010001000},
        {2'b11, 11'b10010001001}, {2'b11, 11'b11010001000}
    };

    logic [12:0] bp_in [4] = '{
        {2'b10, 11'b10101010000}, {2'b10, 11'b11001010000},
        {2'b10, 11'b11010011011}, {2'b10, 11'b11010011010}
    };

    logic [12:0] bad [5] = '{
        {2'b10, 11'b00000000000}, {2'b11, 11'b11111111111},
        {2'b10, 11'b10001011001}, {2'b11, 11'b10001011000},
        {2'b10, 11'b11111111111}
    };

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int total_w;
        int pops0;
        int acc;
        RESETn   = 1'b0;
        InValid  = 1'b1;
        ALUop    = 2'b10;
        Opcode   = 11'b10001011000;
        OutReady = 1'b1;
        ClearErr = 1'b0;

        // Reset held two cycles with input offered.
        repeat (2) @(posedge CLK);
        #1;
        RESETn  = 1'b1;
        InValid = 1'b0;
        mon_en  = 1'b1;
        @(negedge CLK);
        check("rst_out_valid", 16'(OutValid), 16'd0);
        check("rst_alu_ctrl", 16'(ALUCtrl), 16'd0);
        check("rst_illegal", 16'(Illegal), 16'd0);
        check("rst_in_ready", 16'(InReady), 16'd1);
        repeat (3) @(negedge CLK);
        check("rst_no_emit", 16'(pops), 16'd0);

        // Latency: result visible after the second edge.
        @(posedge CLK);
        #1;
        offer(2'b10, 11'b10001011000, w);
        InValid = 1'b0;
        @(negedge CLK);
        check("lat_first_edge", 16'(OutValid), 16'd0);
        @(negedge CLK);
        check("lat_second_edge", 16'(OutValid), 16'd1);
        check("lat_ctrl", 16'(ALUCtrl), 16'b0010);

        // Full legal table streamed back-to-back.
        @(posedge CLK);
        #1;
        pops0   = pops;
        total_w = 0;
        for (int i = 0; i < 12; i++) begin
            offer(tbl[i][12:11], tbl[i][10:0], w);
            total_w += w;
        end
        InValid = 1'b0;
        check("stream_no_wait", 16'(total_w), 16'd0);
        repeat (4) @(negedge CLK);
        check("stream_count", 16'(pops - pops0), 16'd12);
        check("stream_drained", 16'(sb.size()), 16'd0);

        // Illegal inputs, including an X in the ignored immediate bit.
        @(posedge CLK);
        #1;
        offer(2'b10, 11'b11111111111, w);
        offer(2'b11, 11'b0000000000x, w);
        InValid = 1'b0;
        @(negedge CLK);
        check("ill_count", 16'(ErrCount), 16'd2);
        check("ill_sticky", 16'(IllegalSticky), 16'd1);
        repeat (3) @(negedge CLK);

        // Back-pressure: only DEPTH entries fit while the output is stalled.
        @(posedge CLK);
        #1;
        pops0    = pops;
        acc      = 0;
        OutReady = 1'b0;
        InValid  = 1'b1;
        ALUop    = bp_in[0][12:11];
        Opcode   = bp_in[0][10:0];
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (InReady) acc++;
            @(posedge CLK);
            #1;
            ALUop  = bp_in[acc][12:11];
            Opcode = bp_in[acc][10:0];
        end
        @(negedge CLK);
        check("bp_accepted", 16'(acc), 16'(DEPTH));
        check("bp_in_ready", 16'(InReady), 16'd0);
        check("bp_hold_valid", 16'(OutValid), 16'd1);
        check("bp_hold_ctrl", 16'(ALUCtrl), 16'b0001);
        @(posedge CLK);
        #1;
        OutReady = 1'b1;
        for (int i = acc; i < 4; i++) begin
            offer(bp_in[i][12:11], bp_in[i][10:0], w);
        end
        InValid = 1'b0;
        repeat (4) @(negedge CLK);
        check("bp_count", 16'(pops - pops0), 16'd4);
        check("bp_drained", 16'(sb.size()), 16'd0);

        // Saturation, then clear coinciding with an illegal acceptance, then clear alone.
        @(posedge CLK);
        #1;
        for (int i = 0; i < 5; i++) begin
            offer(bad[i][12:11], bad[i][10:0], w);
        end
        InValid = 1'b0;
        @(negedge CLK);
        check("sat_count", 16'(ErrCount), 16'd3);
        @(posedge CLK);
        #1;
        ClearErr = 1'b1;
        offer(2'b10, 11'b00000000001, w);
        ClearErr = 1'b0;
        InValid  = 1'b0;
        @(negedge CLK);
        check("clr_ill_count", 16'(ErrCount), 16'd1);
        check("clr_ill_sticky", 16'(IllegalSticky), 16'd1);
        @(posedge CLK);
        #1;
        ClearErr = 1'b1;
        @(posedge CLK);
        #1;
        ClearErr = 1'b0;
        @(negedge CLK);
        check("clr_count", 16'(ErrCount), 16'd0);
        check("clr_sticky", 16'(IllegalSticky), 16'd0);
        repeat (3) @(negedge CLK);

        // Reset with two entries in flight: they must never emerge.
        @(posedge CLK);
        #1;
        OutReady = 1'b0;
        offer(2'b10, 11'b11001011000, w);
        offer(2'b10, 11'b11001010000, w);
        InValid = 1'b0;
        pops0   = pops;
        RESETn  = 1'b0;
        @(posedge CLK);
        #1;
        RESETn   = 1'b1;
        OutReady = 1'b1;
        @(negedge CLK);
        check("mid_rst_valid", 16'(OutValid), 16'd0);
        check("mid_rst_in_ready", 16'(InReady), 16'd1);
        repeat (5) @(negedge CLK);
        check("mid_rst_no_emit", 16'(pops - pops0), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
